// File: rtl/mult_operand_sequencer_if.sv
// Operand, multiplier-control and result signals of the serial-multiplier sequencer.
// The slave modport is the sequencer side; master is the surrounding producer/multiplier/consumer.
interface mult_operand_sequencer_if #(
  parameter int Width = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [Width-1:0]     in_a;
  logic [Width-1:0]     in_b;
  logic                 mul_en;
  logic [Width-1:0]     mul_a;
  logic [Width-1:0]     mul_b;
  logic                 mul_done;
  logic [2*Width-1:0]   mul_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*Width-1:0]   out_product;
  logic [Width-1:0]     out_a;
  logic [Width-1:0]     out_b;
  logic                 out_err;

  modport slave (
    input  in_valid, in_a, in_b, mul_done, mul_product, out_ready,
    output in_ready, mul_en, mul_a, mul_b, out_valid, out_product, out_a, out_b, out_err
  );

  modport master (
    output in_valid, in_a, in_b, mul_done, mul_product, out_ready,
    input  in_ready, mul_en, mul_a, mul_b, out_valid, out_product, out_a, out_b, out_err
  );
endinterface

// File: rtl/mult_operand_sequencer.sv
// Queues operand pairs and runs them one at a time through a serial multiplier; pop 1 cycle after accept, result 1 cycle after qualified done.
// in_ready drops only when the FIFO is full; a result is held in HOLD until out_ready.
module mult_operand_sequencer #(
  parameter int Width   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  mult_operand_sequencer_if.slave   bus,
  output logic                      busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [Width-1:0] a;
    logic [Width-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t          state, state_nxt;
  pair_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;
  logic            done_hit, tmo_hit, done_armed;
  logic [CW-1:0]   tmo_cnt;

  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = (state == IDLE) && !empty;
  assign busy         = !empty || (state != IDLE);

  // Only a done that follows a low level seen in this WAIT counts, so a stale high is ignored.
  assign done_hit = (state == WAIT) && done_armed && bus.mul_done;
  assign tmo_hit  = (state == WAIT) && !done_hit && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (done_hit || tmo_hit) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mul_en    = (state == LAUNCH);
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mul_a       <= '0;
      bus.mul_b       <= '0;
      bus.out_product <= '0;
      bus.out_a       <= '0;
      bus.out_b       <= '0;
      bus.out_err     <= 1'b0;
      tmo_cnt         <= '0;
      done_armed      <= 1'b0;
    end else begin
      if (pop) begin
        bus.mul_a <= mem[rd_ptr].a;
        bus.mul_b <= mem[rd_ptr].b;
      end
      if (state == LAUNCH) begin
        tmo_cnt    <= '0;
        done_armed <= 1'b0;
      end
      if (state == WAIT) begin
        if (!bus.mul_done) done_armed <= 1'b1;
        if (!done_hit && !tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (done_hit) begin
        bus.out_product <= bus.mul_product;
        bus.out_a       <= bus.mul_a;
        bus.out_b       <= bus.mul_b;
        bus.out_err     <= 1'b0;
      end else if (tmo_hit) begin
        bus.out_product <= '0;
        bus.out_a       <= bus.mul_a;
        bus.out_b       <= bus.mul_b;
        bus.out_err     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Scoreboard bench for mult_operand_sequencer with a behavioural serial-multiplier model.
module tb_mult_operand_sequencer;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int TO = 64;

  typedef struct packed {
    logic       err;
    logic [7:0] p;
    logic [3:0] a;
    logic [3:0] b;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  mult_operand_sequencer_if #(.Width(W)) mif ();

  mult_operand_sequencer #(.Width(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // multiplier model: 0 normal (done 4 cycles after mul_en, held high),
  // 1 stale (keep old done 2 cycles, drop, re-raise with product), 2 never done, 3 manual
  int         mode = 0;
  logic       man_done = 1'b0;
  logic [7:0] man_prod = 8'd0;
  logic       mdl_done = 1'b0;
  logic [7:0] mdl_prod = 8'd0;
  int         en_cnt = 0;
  int         dly = 0;
  bit         raise = 1'b0;
  logic [3:0] ma = 4'd0;
  logic [3:0] mb = 4'd0;

  assign mif.mul_done    = (mode == 3) ? man_done : mdl_done;
  assign mif.mul_product = (mode == 3) ? man_prod : mdl_prod;

  always @(negedge clk) begin
    if (mif.mul_en) begin
      en_cnt++;
      ma = mif.mul_a;
      mb = mif.mul_b;
      raise = 1'b0;
      case (mode)
        0:       begin mdl_done = 1'b0; dly = 4; end
        1:       dly = 2;
        default: begin mdl_done = 1'b0; dly = 0; end
      endcase
    end else if (raise) begin
      mdl_done = 1'b1;
      mdl_prod = 8'(ma) * 8'(mb);
      raise = 1'b0;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        if (mode == 0) begin
          mdl_done = 1'b1;
          mdl_prod = 8'(ma) * 8'(mb);
        end else if (mode == 1) begin
          mdl_done = 1'b0;
          raise = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [3:0] a, input logic [3:0] b, input bit err);
    int g = 0;
    mif.in_valid = 1'b1;
    mif.in_a = a;
    mif.in_b = b;
    while (!mif.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (mif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_accept: in_ready=%0b required 1", mif.in_ready);
    end else begin
      exp_q.push_back({err, err ? 8'd0 : 8'(a) * 8'(b), a, b});
    end
    @(negedge clk);
    mif.in_valid = 1'b0;
  endtask

  task automatic wait_result(output bit ok, output res_t r);
    ok = 1'b0;
    r = '0;
    for (int g = 0; g < 300; g++) begin
      if (mif.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      r = {mif.out_err, mif.out_product, mif.out_a, mif.out_b};
      mif.out_ready = 1'b1;
      @(negedge clk);
      mif.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mif.mul_en, mif.mul_a, mif.mul_b, mif.out_valid, mif.out_product,
         mif.out_a, mif.out_b, mif.out_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%0b a=%h b=%h vld=%0b p=%h oa=%h ob=%h err=%0b required all 0",
               mif.mul_en, mif.mul_a, mif.mul_b, mif.out_valid, mif.out_product,
               mif.out_a, mif.out_b, mif.out_err);
    end
    repeat (3) @(negedge clk);
    total++;
    if (mif.in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_busy: in_ready=%0b busy=%0b required 1 0", mif.in_ready, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mif.in_ready !== 1'b1 || busy !== 1'b0 || mif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: in_ready=%0b busy=%0b out_valid=%0b required 1 0 0",
               mif.in_ready, busy, mif.out_valid);
    end
  endtask

  task automatic test_single_op;
    res_t r, e;
    bit   ok;
    int   c0, lat;
    mode = 0;
    c0 = en_cnt;
    push(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    total++;
    if (mif.mul_en !== 1'b1) begin
      bad++;
      $display("FAIL single_en_latency: mul_en=%0b required 1", mif.mul_en);
    end
    lat = 0;
    while (!mif.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL single_done_latency: cycles=%0d required 5", lat);
    end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (mif.out_valid !== 1'b1 || mif.out_product !== 8'd15) begin
        bad++;
        $display("FAIL single_hold: out_valid=%0b product=%0d required 1 15", mif.out_valid, mif.out_product);
      end
    end
    e = exp_q.pop_front();
    wait_result(ok, r);
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL single_result: got=%h ok=%0b required %h", r, ok, e);
    end
    total++;
    if (mif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_release: out_valid=%0b required 0", mif.out_valid);
    end
    total++;
    if (en_cnt - c0 != 1) begin
      bad++;
      $display("FAIL single_en_count: pulses=%0d required 1", en_cnt - c0);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] av[4] = '{4'd15, 4'd0, 4'd9, 4'd1};
    logic [3:0] bv[4] = '{4'd15, 4'd7, 4'd2, 4'd1};
    res_t r, e;
    bit   ok;
    int   c0;
    mode = 0;
    c0 = en_cnt;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mif.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready[%0d]: in_ready=%0b required 1", i, mif.in_ready);
      end
      push(av[i], bv[i], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      wait_result(ok, r);
      total++;
      if (!ok || r !== e) begin
        bad++;
        $display("FAIL b2b_result[%0d]: got=%h ok=%0b required %h", i, r, ok, e);
      end
    end
    total++;
    if (en_cnt - c0 != 4) begin
      bad++;
      $display("FAIL b2b_en_count: pulses=%0d required 4", en_cnt - c0);
    end
  endtask

  task automatic test_full;
    res_t r, e;
    bit   ok;
    int   g;
    mode = 3;
    man_done = 1'b0;
    man_prod = 8'd0;
    push(4'd1, 4'd2, 1'b0);
    repeat (3) @(negedge clk);
    push(4'd2, 4'd3, 1'b0);
    push(4'd3, 4'd4, 1'b0);
    push(4'd4, 4'd5, 1'b0);
    push(4'd5, 4'd6, 1'b0);
    total++;
    if (mif.in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL full_ready: in_ready=%0b busy=%0b required 0 1", mif.in_ready, busy);
    end
    mif.in_valid = 1'b1;
    mif.in_a = 4'd6;
    mif.in_b = 4'd7;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (mif.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL full_stall: in_ready=%0b required 0", mif.in_ready);
      end
    end
    man_prod = 8'd2;
    man_done = 1'b1;
    @(negedge clk);
    mode = 0;
    e = exp_q.pop_front();
    wait_result(ok, r);
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL full_first: got=%h ok=%0b required %h", r, ok, e);
    end
    g = 0;
    while (!mif.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (mif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_fifth_accept: in_ready=%0b required 1", mif.in_ready);
    end else begin
      exp_q.push_back({1'b0, 8'd42, 4'd6, 4'd7});
    end
    @(negedge clk);
    mif.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      wait_result(ok, r);
      total++;
      if (!ok || r !== e) begin
        bad++;
        $display("FAIL full_order[%0d]: got=%h ok=%0b required %h", i, r, ok, e);
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL full_drained: busy=%0b pending=%0d required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_stale_done;
    res_t r, e;
    bit   ok;
    mode = 0;
    push(4'd3, 4'd5, 1'b0);
    e = exp_q.pop_front();
    wait_result(ok, r);
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL stale_prev: got=%h ok=%0b required %h", r, ok, e);
    end
    mode = 1;
    push(4'd6, 4'd7, 1'b0);
    e = exp_q.pop_front();
    wait_result(ok, r);
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL stale_result: got=%h ok=%0b required %h", r, ok, e);
    end
  endtask

  task automatic test_timeout;
    res_t r, e;
    bit   ok;
    int   lat;
    mode = 2;
    push(4'd3, 4'd3, 1'b1);
    @(negedge clk);
    lat = 0;
    while (!mif.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != TO + 1) begin
      bad++;
      $display("FAIL timeout_latency: cycles=%0d required %0d", lat, TO + 1);
    end
    e = exp_q.pop_front();
    wait_result(ok, r);
    total++;
    if (!ok || r.err !== 1'b1 || r.p !== 8'd0) begin
      bad++;
      $display("FAIL timeout_result: err=%0b product=%0d ok=%0b required 1 0", r.err, r.p, ok);
    end
    mode = 0;
    push(4'd2, 4'd4, 1'b0);
    e = exp_q.pop_front();
    wait_result(ok, r);
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL timeout_next: got=%h ok=%0b required %h", r, ok, e);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit quiet = 1'b1;
    mode = 3;
    man_done = 1'b0;
    man_prod = 8'd0;
    push(4'd7, 4'd7, 1'b0);
    push(4'd2, 4'd2, 1'b0);
    push(4'd3, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || mif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midwait_busy: busy=%0b in_ready=%0b required 1 1", busy, mif.in_ready);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mif.mul_en, mif.mul_a, mif.mul_b, mif.out_valid, mif.out_product,
         mif.out_a, mif.out_b, mif.out_err, busy} !== '0 || mif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midwait_reset: en=%0b a=%h b=%h vld=%0b p=%h busy=%0b rdy=%0b required 0s rdy=1",
               mif.mul_en, mif.mul_a, mif.mul_b, mif.out_valid, mif.out_product, busy, mif.in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    man_prod = 8'd99;
    man_done = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mif.out_valid !== 1'b0 || mif.mul_en !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    man_done = 1'b0;
    @(negedge clk);
    man_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mif.out_valid !== 1'b0 || mif.mul_en !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL midwait_ignore_done: activity=1 required 0 (vld=%0b en=%0b busy=%0b)",
               mif.out_valid, mif.mul_en, busy);
    end
    mode = 0;
  endtask

  initial begin
    mif.in_valid  = 1'b0;
    mif.in_a      = 4'd0;
    mif.in_b      = 4'd0;
    mif.out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_full();
    test_stale_done();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mult_operand_sequencer.md
MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
  Width, 4, operand width in bits; product is 2*Width.
  DEPTH, 4, operand FIFO entries (power of 2, >=2).
  TIMEOUT, 64, max WAIT cycles before error completion.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all logic on rising edge.
  reset  in  1  asynchronous, active-low reset.
  in_valid  in  1  operand pair offered.
  in_ready  out  1  FIFO can accept.
  in_a  in  Width  multiplicand.
  in_b  in  Width  multiplier.
  mul_en  out  1  one-cycle start pulse to the serial multiplier's Enable.
  mul_a  out  Width  multiplicand to the multiplier.
  mul_b  out  Width  multiplier operand to the multiplier.
  mul_done  in  1  multiplier done level.
  mul_product  in  2*Width  multiplier result.
  out_valid  out  1  result available.
  out_ready  in  1  consumer accepts result.
  out_product  out  2*Width  captured product.
  out_a  out  Width  multiplicand of this result.
  out_b  out  Width  multiplier of this result.
  out_err  out  1  result ended by timeout.
  busy  out  1  FIFO non-empty or state != IDLE.

Function
REQ-003 Input handshake SHALL write {in_a,in_b} into the FIFO on a rising edge with in_valid && in_ready; in_ready SHALL equal !full (combinational), with no bypass when full.
REQ-004 The FSM SHALL have the states IDLE, LAUNCH, WAIT and HOLD.
REQ-005 IDLE with FIFO non-empty: pop the head into mul_a/mul_b, go to LAUNCH. IDLE with FIFO empty: stay in IDLE.
REQ-006 LAUNCH: mul_en=1 for exactly this one cycle, clear done_armed and the timeout counter, go to WAIT. mul_en SHALL be 0 in every other state.
REQ-007 mul_a/mul_b SHALL hold stable from the pop until the exit from HOLD.
REQ-008 WAIT: done_armed SHALL set on the first cycle mul_done=0. This ignores a done level still high from the previous operation.
REQ-009 WAIT with done_armed && mul_done: capture mul_product into out_product, copy mul_a/mul_b into out_a/out_b, set out_err=0, go to HOLD.
REQ-010 WAIT SHALL increment the timeout counter each cycle. When the count reaches TIMEOUT-1 without a qualified done, the block SHALL go to HOLD with out_product=0 and out_err=1.
REQ-011 HOLD: out_valid=1 and all out_* stable. On out_ready=1, go to IDLE with out_valid=0 at the next edge.
REQ-012 Latency from an accept edge E0 with the FIFO empty and state IDLE:
  pop/load at E1;
  mul_en high between E1 and E2;
  out_valid high one cycle after the qualifying-done edge.
REQ-013 FIFO pushes SHALL be allowed in every state. A simultaneous push and pop SHALL leave the count unchanged.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH. Order SHALL be strictly FIFO.
REQ-015 busy SHALL be combinational: (count != 0) || (state != IDLE).

Reset
REQ-016 Asserting reset (low) SHALL asynchronously set, in any state including mid-WAIT:
  state=IDLE, FIFO empty, mul_en=0, mul_a=mul_b=0;
  out_valid=0, out_product=0, out_a=out_b=0, out_err=0;
  counter=0, done_armed=0.
REQ-017 During and after reset, in_ready SHALL be 1 and busy 0. A mul_done arriving after reset release SHALL be ignored until a new LAUNCH.

Verification
REQ-018 Single op: push (3,5); model asserts done 4 cycles after mul_en -> exactly one mul_en pulse, out_product=15, out_err=0, out_valid held until out_ready.
REQ-019 Back-to-back: push (15,15),(0,7),(9,2),(1,1) on consecutive cycles -> in_ready stays 1, results in order 225,0,18,1, one mul_en per result.
REQ-020 Full: push 5 pairs while the first is in WAIT -> in_ready=0 after the FIFO is full, 5th pair not written until a pop, no loss or duplication.
REQ-021 Stale done: model holds mul_done=1 continuously from the previous op, drops it 2 cycles after mul_en, re-raises it with 42 -> out_product=42, not the stale value.
REQ-022 Timeout: model never asserts done -> out_valid after TIMEOUT WAIT cycles with out_err=1, out_product=0; next op proceeds normally.
REQ-023 Reset mid-WAIT with 2 pairs queued -> all outputs 0 immediately, queue discarded, later mul_done ignored, busy=0.
